// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master bridging a simple core request/response port.
// Bus valid/ready outputs are decoded from state so a timeout or reset drops them on the next cycle.
module axi_lite_master #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [31:0] ARADDR,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] AWADDR,
    output logic        WVALID,
    input  logic        WREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [1:0]  BRESP
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_ready_q;
    logic        aw_hs, w_hs, timeout;

    assign req_ready = req_ready_q;
    assign ARVALID   = (state_q == S_RD_ADDR);
    assign RREADY    = (state_q == S_RD_DATA);
    assign AWVALID   = (state_q == S_WR_REQ) && !aw_done_q;
    assign WVALID    = (state_q == S_WR_REQ) && !w_done_q;
    assign BREADY    = (state_q == S_WR_RESP);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ARADDR    = addr_q;
    assign AWADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;

    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign timeout = (cnt_q == TIMEOUT);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                cnt_d = cnt_q + 8'd1;
                if (ARREADY) begin
                    state_d = S_RD_DATA;
                end else if (timeout) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            S_RD_DATA: begin
                cnt_d = cnt_q + 8'd1;
                if (RVALID) begin
                    state_d = S_RSP;
                    err_d   = (RRESP != 2'b00);
                    rdata_d = (RRESP == 2'b00) ? RDATA : '0;
                end else if (timeout) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            S_WR_REQ: begin
                cnt_d     = cnt_q + 8'd1;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                // Either channel handshaking in the timeout cycle defers the timeout.
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end else if (timeout && !aw_hs && !w_hs) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            S_WR_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (BVALID) begin
                    state_d = S_RSP;
                    err_d   = (BRESP != 2'b00);
                    rdata_d = '0;
                end else if (timeout) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= (state_d == S_IDLE);
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: main process drives core and slave cycle by cycle,
// a negedge monitor pops expected responses from a scoreboard queue.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] ARADDR, RDATA;
    logic [1:0]  RRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;

    always #5 clk = ~clk;

    axi_lite_master #(.TIMEOUT(8'd5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err);
        exp_q.push_back('{rdata: rdata, err: err});
    endtask

    // Returns one ns after the accepting edge, i.e. at the start of cycle 1.
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        int unsigned n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        tick();
        req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            chk("rsp_with_axi_valid", {29'b0, ARVALID, AWVALID, WVALID}, 32'd0);
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                             rsp_rdata, rsp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b1;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;

        // Reset state and first ready
        repeat (3) tick();
        chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_valids", {27'b0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
        chk("reset_rsp_data", {rsp_rdata[30:0], rsp_err}, 32'd0);
        rst = 1'b1;
        tick();
        chk("req_ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Zero-wait read
        expect_rsp(32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'h8000_0010, 32'h0, 4'hF);
        chk("rd_arvalid", {31'b0, ARVALID}, 32'd1);
        chk("rd_araddr", ARADDR, 32'h8000_0010);
        chk("rd_wstrb", {28'b0, WSTRB}, 32'hF);
        chk("rd_req_ready_busy", {31'b0, req_ready}, 32'd0);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        chk("rd_arvalid_drop", {31'b0, ARVALID}, 32'd0);
        chk("rd_rready", {31'b0, RREADY}, 32'd1);
        RVALID = 1'b1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
        tick();
        RVALID = 1'b0;
        chk("rd_latency3", {31'b0, rsp_valid}, 32'd1);
        chk("rd_rready_drop", {31'b0, RREADY}, 32'd0);
        tick();
        chk("rd_idle_ready", {31'b0, req_ready}, 32'd1);

        // Skewed write; early BVALID while in WR_REQ must be ignored
        expect_rsp(32'h0, 1'b0);
        issue(1'b1, 32'h8000_0020, 32'h1234_5678, 4'h3);
        chk("wr_awvalid", {31'b0, AWVALID}, 32'd1);
        chk("wr_wvalid", {31'b0, WVALID}, 32'd1);
        chk("wr_awaddr", AWADDR, 32'h8000_0020);
        chk("wr_wdata", WDATA, 32'h1234_5678);
        chk("wr_wstrb", {28'b0, WSTRB}, 32'h3);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        chk("wr_awvalid_drop", {31'b0, AWVALID}, 32'd0);
        chk("wr_wvalid_hold2", {31'b0, WVALID}, 32'd1);
        chk("wr_bready_early2", {31'b0, BREADY}, 32'd0);
        BVALID = 1'b1; BRESP = 2'b11;
        tick();
        BVALID = 1'b0; BRESP = 2'b00;
        chk("wr_wvalid_hold3", {31'b0, WVALID}, 32'd1);
        chk("wr_bready_early3", {31'b0, BREADY}, 32'd0);
        tick();
        chk("wr_wvalid_hold4", {31'b0, WVALID}, 32'd1);
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        chk("wr_wvalid_drop", {31'b0, WVALID}, 32'd0);
        chk("wr_bready", {31'b0, BREADY}, 32'd1);
        BVALID = 1'b1;
        tick();
        BVALID = 1'b0;
        chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        tick();

        // Read error response
        expect_rsp(32'h0, 1'b1);
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h1);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h0; RRESP = 2'b10;
        tick();
        RVALID = 1'b0; RRESP = 2'b00;
        tick();

        // Simultaneous AW/W handshake, write error
        expect_rsp(32'h0, 1'b1);
        issue(1'b1, 32'h0000_0200, 32'hAAAA_5555, 4'hF);
        AWREADY = 1'b1; WREADY = 1'b1;
        tick();
        AWREADY = 1'b0; WREADY = 1'b0;
        chk("wr2_valids_drop", {30'b0, AWVALID, WVALID}, 32'd0);
        chk("wr2_bready_one_step", {31'b0, BREADY}, 32'd1);
        BVALID = 1'b1; BRESP = 2'b11;
        tick();
        BVALID = 1'b0; BRESP = 2'b00;
        chk("wr2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        tick();

        // Timeout: ARREADY never comes, counter hits 5 in cycle 6
        expect_rsp(32'h0, 1'b1);
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        for (int i = 1; i <= 6; i++) begin
            chk("to_arvalid_held", {31'b0, ARVALID}, 32'd1);
            tick();
        end
        chk("to_arvalid_drop", {31'b0, ARVALID}, 32'd0);
        chk("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        tick();

        // ARREADY in the timeout cycle wins
        expect_rsp(32'hCAFE_F00D, 1'b0);
        issue(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        repeat (5) tick();
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        chk("to_hs_rready", {31'b0, RREADY}, 32'd1);
        chk("to_hs_no_rsp", {31'b0, rsp_valid}, 32'd0);
        RVALID = 1'b1; RDATA = 32'hCAFE_F00D;
        tick();
        RVALID = 1'b0;
        chk("to_hs_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        tick();

        // Back-pressure on the response
        rsp_ready = 1'b0;
        expect_rsp(32'h0000_A5A5, 1'b0);
        issue(1'b0, 32'h0000_0500, 32'h0, 4'hF);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h0000_A5A5;
        tick();
        RVALID = 1'b0; RDATA = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h0000_A5A5);
            chk("bp_rsp_err", {31'b0, rsp_err}, 32'd0);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();

        // Reset during WR_REQ abandons the write
        issue(1'b1, 32'h0000_0600, 32'h0BAD_F00D, 4'hF);
        chk("rst_wr_awvalid", {31'b0, AWVALID}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_valids", {27'b0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        tick();
        chk("rst_req_ready_rise", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
            tick();
        end

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
